// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: memory-owner encoding and burst-lock states.
package tiny16_pkg;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  typedef enum logic {
    LockUnlocked,
    LockLockedExt
  } lock_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has fixed priority, the external master gets an
// anti-starvation override and a burst lock. Read data returns one cycle after grant.
module mem_arbiter
  import tiny16_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  lock_state_e lock_q, lock_d;
  logic [3:0]  wait_q, wait_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_owner_q, rd_owner_d;
  logic        ext_prio;

  assign ext_prio = (lock_q == LockLockedExt) || (wait_q == MaxWait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= LockUnlocked;
      wait_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CPU;
    end else begin
      lock_q     <= lock_d;
      wait_q     <= wait_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    lock_d = lock_q;
    unique case (lock_q)
      LockUnlocked:  if (ext_gnt && ext_lock) lock_d = LockLockedExt;
      LockLockedExt: if (!ext_lock) lock_d = LockUnlocked;
      default:       lock_d = LockUnlocked;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!ext_req || ext_gnt) begin
      wait_d = '0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // While locked the CPU is shut out even on idle cycles of the burst.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      if (lock_q == LockLockedExt) begin
        ext_gnt = ext_req;
      end else if (ext_req && (ext_prio || !cpu_req)) begin
        ext_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | ext_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign rd_valid_d = (cpu_gnt && !cpu_we) || (ext_gnt && !ext_we);
  assign rd_owner_d = ext_gnt ? OWN_EXT : OWN_CPU;

  always_comb begin
    cpu_rvalid = rd_valid_q && (rd_owner_q == OWN_CPU);
    ext_rvalid = rd_valid_q && (rd_owner_q == OWN_EXT);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    ext_rdata  = ext_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, checked by a
// reference arbiter model and read-return scoreboard.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_lock  (ext_lock),
    .ext_gnt   (ext_gnt),
    .ext_rvalid(ext_rvalid),
    .ext_rdata (ext_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous memory the arbiter drives, plus the model's own copy of its contents.
  logic [15:0] mem    [0:1023];
  logic [15:0] shadow [0:1023];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  function automatic logic [15:0] init_val(input int i);
    return (i == 16'h0010) ? 16'h1234 : (16'(i * 3) ^ 16'h5a5a);
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t ext_q[$];

  // Reference arbiter: who wins this cycle, what the memory should see, what reads return.
  int m_wait   = 0;
  bit m_locked = 0;
  bit g_cpu    = 0;
  bit g_ext    = 0;

  always @(negedge clk) begin
    bit e_cpu, e_ext;
    g_cpu = cpu_gnt;
    g_ext = ext_gnt;
    if (rst) begin
      m_wait   = 0;
      m_locked = 0;
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_ext_gnt", ext_gnt, 0);
      check("rst_mem_en", mem_en, 0);
    end else begin
      e_ext = ext_req && (m_locked || m_wait >= MW || !cpu_req);
      e_cpu = cpu_req && !m_locked && !e_ext;
      check("cpu_gnt", cpu_gnt, e_cpu);
      check("ext_gnt", ext_gnt, e_ext);
      check("mem_en", mem_en, e_cpu || e_ext);
      check("mem_we", mem_we, e_cpu ? cpu_we : (e_ext ? ext_we : 1'b0));
      check("mem_addr", mem_addr, e_cpu ? cpu_addr : (e_ext ? ext_addr : 16'h0));
      check("mem_wdata", mem_wdata, e_cpu ? cpu_wdata : (e_ext ? ext_wdata : 16'h0));
      if (e_cpu) begin
        if (cpu_we) shadow[cpu_addr[9:0]] = cpu_wdata;
        else cpu_q.push_back('{due: cyc + 1, data: shadow[cpu_addr[9:0]]});
      end
      if (e_ext) begin
        if (ext_we) shadow[ext_addr[9:0]] = ext_wdata;
        else ext_q.push_back('{due: cyc + 1, data: shadow[ext_addr[9:0]]});
      end
      m_wait   = (ext_req && !e_ext) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      m_locked = m_locked ? ext_lock : (e_ext && ext_lock);
    end
  end

  // Monitor: every returned word must match the oldest expected read for that master.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_ext_rvalid", ext_rvalid, 0);
      cpu_q.delete();
      ext_q.delete();
    end else begin
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        check("cpu_rvalid", cpu_rvalid, 1);
        check("cpu_rdata", cpu_rdata, cpu_q[0].data);
        void'(cpu_q.pop_front());
      end else begin
        check("cpu_rvalid_idle", cpu_rvalid, 0);
        check("cpu_rdata_idle", cpu_rdata, 0);
      end
      if (ext_q.size() > 0 && ext_q[0].due == cyc) begin
        check("ext_rvalid", ext_rvalid, 1);
        check("ext_rdata", ext_rdata, ext_q[0].data);
        void'(ext_q.pop_front());
      end else begin
        check("ext_rvalid_idle", ext_rvalid, 0);
        check("ext_rdata_idle", ext_rdata, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb, k_first, k_last;
    rst = 1'b1;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0011; ext_wdata = '0; ext_lock = 1'b0;

    // Reset with both masters requesting
    repeat (2) @(posedge clk);
    #4;
    check("rst_all_gnt", {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_en, mem_we}, 0);
    check("rst_all_bus", {mem_addr, mem_wdata}, 0);
    check("rst_all_rdata", {cpu_rdata, ext_rdata}, 0);

    step(); rst = 1'b0; ext_req = 1'b0;
    #3 check("boot_cpu_gnt", cpu_gnt, 1);
    step(); cpu_req = 1'b0;
    #3 check("boot_rvalid", cpu_rvalid, 1);
    check("boot_rdata", cpu_rdata, 16'h1234);

    // Contention: CPU four times, then the starved external master
    step(); cpu_req = 1'b1; cpu_addr = 16'h0011; ext_req = 1'b1; ext_addr = 16'h0030;
    for (int i = 0; i < 10; i++) begin
      #3 check($sformatf("contend_ext_%0d", i), ext_gnt, (i % 5) == 4);
      check($sformatf("contend_cpu_%0d", i), cpu_gnt, (i % 5) != 4);
      step();
    end
    cpu_req = 1'b0; ext_req = 1'b0;

    // Locked burst of four external writes against a requesting CPU
    step();
    cpu_req = 1'b1; cpu_addr = 16'h0012;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0100; ext_wdata = 16'hB000; ext_lock = 1'b1;
    nb = 0; k_first = -1; k_last = -1;
    for (int k = 0; k < 20 && nb < 4; k++) begin
      #3;
      if (ext_gnt) begin
        nb++;
        if (k_first < 0) k_first = k;
        k_last = k;
        check("burst_cpu_blocked", cpu_gnt, 0);
      end
      step();
      if (g_ext) begin
        ext_addr = 16'(16'h0100 + nb); ext_wdata = 16'(16'hB000 + nb);
        if (nb == 3) ext_lock = 1'b0;
        if (nb == 4) begin ext_req = 1'b0; ext_we = 1'b0; end
      end
    end
    check("burst_count", nb, 4);
    check("burst_first", k_first, 4);
    check("burst_last", k_last, 7);
    #3 check("burst_cpu_after", cpu_gnt, 1);
    step(); cpu_addr = 16'h0103;
    #3 check("burst_rd_gnt", cpu_gnt, 1);
    step(); cpu_req = 1'b0;
    #3 check("burst_rd_data", cpu_rdata, 16'hB003);

    // Read routing, back-to-back masters
    step(); cpu_req = 1'b1; cpu_addr = 16'h0020;
    step(); cpu_req = 1'b0; ext_req = 1'b1; ext_addr = 16'h0021;
    #3 check("route_cpu_rvalid", cpu_rvalid, 1);
    check("route_ext_quiet", ext_rvalid, 0);
    check("route_cpu_data", cpu_rdata, init_val(16'h0020));
    step(); ext_req = 1'b0;
    #3 check("route_ext_rvalid", ext_rvalid, 1);
    check("route_cpu_quiet", cpu_rvalid, 0);
    check("route_ext_data", ext_rdata, init_val(16'h0021));

    // Cancelled external write under contention; counter must restart from zero
    step(); cpu_req = 1'b1; cpu_addr = 16'h0013;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0040; ext_wdata = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      #3 check("cancel_no_gnt", ext_gnt, 0);
      check("cancel_no_write", mem_we, 0);
      step();
    end
    ext_req = 1'b0; ext_we = 1'b0;
    step(); ext_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3 check($sformatf("cancel_restart_%0d", i), ext_gnt, i == 4);
      step();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    #3 check("cancel_mem_intact", ext_rdata, init_val(16'h0040));

    // Reset pulse the cycle after a granted read
    step(); cpu_req = 1'b1; cpu_addr = 16'h0014;
    #3 check("rstmid_gnt", cpu_gnt, 1);
    step(); rst = 1'b1; cpu_req = 1'b0;
    #3 check("rstmid_no_rvalid", {cpu_rvalid, ext_rvalid}, 0);
    step(); rst = 1'b0;
    #3 check("rstmid_after", {cpu_rvalid, ext_rvalid}, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (!cpu_req || g_cpu) begin
        cpu_req   = $urandom_range(0, 99) < 60;
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 16'($urandom_range(0, 63));
        cpu_wdata = 16'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        cpu_req = 1'b0;
      end
      if (!ext_req || g_ext) begin
        ext_req   = $urandom_range(0, 99) < 40;
        ext_we    = $urandom_range(0, 1) == 1;
        ext_addr  = 16'($urandom_range(0, 63));
        ext_wdata = 16'($urandom);
        ext_lock  = $urandom_range(0, 3) == 0;
      end else if ($urandom_range(0, 99) < 5) begin
        ext_req = 1'b0;
      end
    end
    step(); rst = 1'b0; cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    repeat (3) step();
    check("drain_empty", cpu_q.size() + ext_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing the tiny16 main memory between the CPU bus path (fetch, LD*/ST*, PUSH/POP, indirect ALU operands) and one external master (boot loader / display DMA). Requests are granted one word per cycle: fixed CPU priority, with an anti-starvation counter and an external burst lock. Read data returns one cycle after grant and is routed back to the granted master.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width
- MAX_WAIT, 4, consecutive denied cycles after which the external master wins priority (range 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  access accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (read granted previous cycle)
- cpu_rdata  out  DATA_W  read data to CPU
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external master request, same rules as CPU
- ext_lock  in  1  keep ownership for a burst while asserted
- ext_gnt, ext_rvalid, ext_rdata  out  1/1/DATA_W  external master response
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous memory read data, valid one cycle after mem_en & ~mem_we

## Operation
- Grant decision is combinational from current requests and registered state; at most one gnt per cycle.
- Priority: CPU wins by default. External wins if (a) wait_cnt == MAX_WAIT, or (b) lock_owner == EXT.
- wait_cnt: increments when ext_req && !ext_gnt, saturates at MAX_WAIT, clears on ext_gnt or when ext_req low.
- Burst lock: states UNLOCKED, LOCKED_EXT. UNLOCKED -> LOCKED_EXT on cycle with ext_gnt && ext_lock. LOCKED_EXT -> UNLOCKED when ext_lock low (same cycle sampled). In LOCKED_EXT, cpu_gnt = 0 even when ext_req is low (idle locked cycles allowed).
- Memory mux: mem_en = cpu_gnt | ext_gnt; mem_addr/mem_wdata/mem_we from granted master; when none granted mem_en=0, mem_we=0, addr/wdata = 0.
- Read return: rd_owner register captures {valid, owner} for a granted read; next cycle the owner's rvalid = 1 and rdata = mem_rdata. Non-owner rdata = 0. Writes produce no rvalid.
- Requester must hold req/we/addr/wdata stable until gnt; dropping req before gnt is legal and cancels with no memory access.

## Timing
- Reset: cpu_gnt=ext_gnt=0, rvalid both 0, rdata 0, mem_en=mem_we=0, mem_addr=mem_wdata=0, wait_cnt=0, lock UNLOCKED, rd_owner invalid. Gnts masked while rst high.
- Uncontended latency: gnt same cycle as req; read data cycle+1.
- Back-to-back: new grant allowed every cycle; a read's rvalid may coincide with next grant.
- Simultaneous req, wait_cnt < MAX_WAIT: CPU granted. wait_cnt == MAX_WAIT: EXT granted, counter clears.
- Reset asserted mid-read: pending rvalid dropped; no rvalid after reset release.
- ext_lock asserted without grant: no effect until ext_gnt.

## Structure
- Shared package tiny16_pkg: owner encoding (OWN_CPU=0, OWN_EXT=1), lock state constants.
- Single module; no sub-module needed (optional mem_port_mux combinational helper not warranted).

## Test plan
- Reset: rst high with both reqs -> all outputs 0; release -> CPU read addr 0x0010 granted same cycle, cpu_rvalid next cycle with memory contents 0x1234.
- Contention: cpu_req and ext_req held continuously, MAX_WAIT=4 -> CPU granted 4 cycles, EXT granted cycle 5, pattern repeats.
- Lock burst: ext writes 0x0100..0x0103 with ext_lock, CPU requesting -> 4 ext grants consecutive, cpu_gnt 0 until lock drops, CPU granted next cycle.
- Read routing: CPU read 0x0020 then EXT read 0x0021 back-to-back -> cpu_rvalid at t+1, ext_rvalid at t+2, correct data each, no cross-delivery.
- Cancelled request: ext_req 2 cycles under CPU contention then dropped -> no ext_gnt, no memory write, wait_cnt back to 0.
- Reset mid-read: rst pulse the cycle after a granted read -> no rvalid seen by either master.
